x2_multiplier: RTL and testbench

Final stage of the three-stage multiplier in the MEM cluster; it is the consumer end of the x1x2 FIFO. It pops one carry-save pair (S0, S1) per transaction plus the SELECT_MSB and SIGNED flags. It resolves the pair with a two-cycle split carry-propagate adder (low half, then high half with the registered carry). It returns the selected 32-bit word to the writeback path over a valid/ready handshake.

---
 rtl/x2_multiplier_if.sv | 44 ++++
 rtl/x2_multiplier.sv | 169 ++++++++++++++++
 tb/tb_x2_multiplier.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/x2_multiplier_if.sv
// ----------------------------------------------------------------------------
// x2_multiplier_if
//
// Signal bundle between the final multiplier stage, the x1x2 FIFO head it
// consumes, and the writeback path it feeds.
//
//   RES_RX1          FIFO head: [127:64]=S1, [63:0]=S0 carry-save pair
//   SELECT_MSB_RX1   1: return product[63:32], 0: product[31:0]
//   SIGNED_RES_RX1   signedness tag, forwarded unchanged
//   X1X2_EMPTY_SX1   FIFO empty
//   X1X2_POP_SX2     pop FIFO head this cycle
//   FLUSH_SX2        kill every in-flight operation
//   RES_READY_SX2    writeback accepts the result this cycle
//   MULT_RES_RX2     selected 32-bit result word
//   MULT_SIGNED_RX2  forwarded signedness tag
//   MULT_VALID_RX2   result and tag are valid
//
// slave  : the multiplier stage itself
// master : the environment (FIFO + writeback + pipeline control)
// ----------------------------------------------------------------------------
interface x2_multiplier_if;
    logic [127:0] RES_RX1;
    logic         SELECT_MSB_RX1;
    logic         SIGNED_RES_RX1;
    logic         X1X2_EMPTY_SX1;
    logic         X1X2_POP_SX2;
    logic         FLUSH_SX2;
    logic         RES_READY_SX2;
    logic [31:0]  MULT_RES_RX2;
    logic         MULT_SIGNED_RX2;
    logic         MULT_VALID_RX2;

    modport slave (
        input  RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1,
        input  FLUSH_SX2, RES_READY_SX2,
        output X1X2_POP_SX2, MULT_RES_RX2, MULT_SIGNED_RX2, MULT_VALID_RX2
    );

    modport master (
        output RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1,
        output FLUSH_SX2, RES_READY_SX2,
        input  X1X2_POP_SX2, MULT_RES_RX2, MULT_SIGNED_RX2, MULT_VALID_RX2
    );
endinterface

// File: rtl/x2_multiplier.sv
// ----------------------------------------------------------------------------
// x2_multiplier
//
// Final stage of the three-stage multiplier. Pops one carry-save pair
// (S0, S1) from the x1x2 FIFO, resolves it with a two-cycle split
// carry-propagate adder and hands the selected 32-bit word to writeback.
//
//   Stage A: low SPLIT bits added, carry-out registered together with the
//            untouched high slices and the SELECT_MSB / SIGNED flags.
//   Stage B: high slices added with the registered carry, word selected
//            and registered as the output.
//
// Parameters
//   SPLIT    cut position of the 64-bit add between the stages (1..63)
//
// Ports
//   clk      core clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      x2_multiplier_if.slave (FIFO head, flush, result handshake)
//
// Flow control is a combinational ready chain from the output back to the
// FIFO pop, so a full pipeline sustains one result per cycle and holds
// exactly two entries while writeback stalls.
// ----------------------------------------------------------------------------
module x2_multiplier #(
    parameter int SPLIT = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    x2_multiplier_if.slave     bus
);

    localparam int HI_W = 64 - SPLIT;

    typedef struct packed {
        logic [SPLIT-1:0] lo_sum;
        logic             c_lo;
        logic [HI_W-1:0]  s0_hi;
        logic [HI_W-1:0]  s1_hi;
        logic             sel_msb;
        logic             sgn;
    } a_stage_t;

    typedef struct packed {
        logic [31:0] res;
        logic        sgn;
    } b_stage_t;

    logic [63:0] s0;
    logic [63:0] s1;
    logic [SPLIT:0] lo_full;
    logic [HI_W-1:0] hi_sum;
    logic [63:0] product;

    a_stage_t a_q, a_d;
    b_stage_t b_q, b_d;

    logic a_valid;
    logic b_valid;
    logic a_ready;
    logic b_ready;
    logic pop;
    logic a_adv;
    logic out_fire;

    assign s0 = bus.RES_RX1[63:0];
    assign s1 = bus.RES_RX1[127:64];

    // ------------------------------------------------------------------
    // Ready chain
    // ------------------------------------------------------------------
    assign b_ready  = !b_valid || bus.RES_READY_SX2;
    assign a_ready  = !a_valid || b_ready;
    assign a_adv    = a_valid && b_ready;
    assign out_fire = b_valid && bus.RES_READY_SX2;

    // reset_n gates the pop so the FIFO is never drained while the stage
    // is held in reset, independent of the cleared valid bits.
    assign pop = reset_n && !bus.X1X2_EMPTY_SX1 && a_ready && !bus.FLUSH_SX2;

    // ------------------------------------------------------------------
    // Stage A datapath: low half of the carry-propagate add
    // ------------------------------------------------------------------
    // One extra bit on the low add captures the carry into the high half.
    assign lo_full = {1'b0, s0[SPLIT-1:0]} + {1'b0, s1[SPLIT-1:0]};

    always_comb begin
        a_d         = '0;
        a_d.lo_sum  = lo_full[SPLIT-1:0];
        a_d.c_lo    = lo_full[SPLIT];
        a_d.s0_hi   = s0[63:SPLIT];
        a_d.s1_hi   = s1[63:SPLIT];
        a_d.sel_msb = bus.SELECT_MSB_RX1;
        a_d.sgn     = bus.SIGNED_RES_RX1;
    end

    // ------------------------------------------------------------------
    // Stage B datapath: high half plus registered carry, word select
    // ------------------------------------------------------------------
    // The high add truncates naturally to HI_W bits, giving the modulo
    // 2^64 product.
    assign hi_sum  = a_q.s0_hi + a_q.s1_hi + HI_W'(a_q.c_lo);
    assign product = {hi_sum, a_q.lo_sum};

    always_comb begin
        b_d     = '0;
        b_d.res = a_q.sel_msb ? product[63:32] : product[31:0];
        b_d.sgn = a_q.sgn;
    end

    // ------------------------------------------------------------------
    // Valid bits
    // ------------------------------------------------------------------
    // Flush wins over everything, including a simultaneous output
    // handshake: the result is simply dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
        end else if (bus.FLUSH_SX2) begin
            a_valid <= 1'b0;
        end else if (pop) begin
            a_valid <= 1'b1;
        end else if (a_adv) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_valid <= 1'b0;
        end else if (bus.FLUSH_SX2) begin
            b_valid <= 1'b0;
        end else if (a_adv) begin
            b_valid <= 1'b1;
        end else if (out_fire) begin
            b_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    // FIFO data is captured only on a pop; B only on an advance, so a
    // stalled output stays stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
        end else if (pop) begin
            a_q <= a_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_q <= '0;
        end else if (a_adv) begin
            b_q <= b_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.X1X2_POP_SX2    = pop;
    assign bus.MULT_RES_RX2    = b_q.res;
    assign bus.MULT_SIGNED_RX2 = b_q.sgn;
    assign bus.MULT_VALID_RX2  = b_valid;

endmodule

// File: tb/tb_x2_multiplier.sv
// ----------------------------------------------------------------------------
// tb_x2_multiplier
//
// Directed bench for x2_multiplier. A small FIFO model feeds the stage;
// every pop pushes the reference result (plain 64-bit S0+S1, word select)
// to a scoreboard queue which is popped whenever an output transfer
// completes. Outputs are sampled on the falling edge; inputs change 1 ns
// after the rising edge.
// ----------------------------------------------------------------------------
module tb_x2_multiplier;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    x2_multiplier_if bus();

    x2_multiplier #(.SPLIT(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        sgn;
    } exp_t;

    // FIFO model storage
    logic [63:0] m_s0 [128];
    logic [63:0] m_s1 [128];
    logic        m_sel[128];
    logic        m_sgn[128];
    logic [6:0]  wr_ptr;
    logic [6:0]  rd_ptr;
    bit          pend_pop;

    exp_t exp_q[$];

    int n_cmp;
    int n_err;
    int cyc;
    int n_pops;
    int out_cnt;
    int last_pop_cyc;
    int last_out_cyc;
    logic [31:0] last_out_res;
    logic        last_out_sgn;

    function automatic exp_t model(input logic [63:0] s0, input logic [63:0] s1,
                                   input logic sel, input logic sgn);
        logic [63:0] prod;
        exp_t e;
        prod  = s0 + s1;
        e.res = sel ? prod[63:32] : prod[31:0];
        e.sgn = sgn;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
        end
    endtask

    task automatic drive_head();
        bus.X1X2_EMPTY_SX1 = (rd_ptr == wr_ptr);
        if (rd_ptr != wr_ptr) begin
            bus.RES_RX1        = {m_s1[rd_ptr], m_s0[rd_ptr]};
            bus.SELECT_MSB_RX1 = m_sel[rd_ptr];
            bus.SIGNED_RES_RX1 = m_sgn[rd_ptr];
        end else begin
            bus.RES_RX1        = '0;
            bus.SELECT_MSB_RX1 = 1'b0;
            bus.SIGNED_RES_RX1 = 1'b0;
        end
    endtask

    task automatic push(input logic [63:0] s0, input logic [63:0] s1,
                        input logic sel, input logic sgn);
        m_s0[wr_ptr]  = s0;
        m_s1[wr_ptr]  = s1;
        m_sel[wr_ptr] = sel;
        m_sgn[wr_ptr] = sgn;
        wr_ptr = wr_ptr + 7'd1;
        drive_head();
    endtask

    // One clock: monitor on the falling edge, FIFO head update after the
    // rising edge. Returns 1 ns after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!reset_n || bus.FLUSH_SX2) begin
            exp_q.delete();
        end else if (bus.MULT_VALID_RX2 && bus.RES_READY_SX2) begin
            out_cnt++;
            last_out_cyc = cyc;
            last_out_res = bus.MULT_RES_RX2;
            last_out_sgn = bus.MULT_SIGNED_RX2;
            check("sb_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_res", 64'(bus.MULT_RES_RX2), 64'(e.res));
                check("sb_sgn", 64'(bus.MULT_SIGNED_RX2), 64'(e.sgn));
            end
        end
        if (bus.X1X2_POP_SX2) begin
            n_pops++;
            last_pop_cyc = cyc;
            check("pop_nonempty", 64'(rd_ptr != wr_ptr), 64'(1));
            if (rd_ptr != wr_ptr) begin
                exp_q.push_back(model(m_s0[rd_ptr], m_s1[rd_ptr], m_sel[rd_ptr], m_sgn[rd_ptr]));
                pend_pop = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (pend_pop) begin
            rd_ptr   = rd_ptr + 7'd1;
            pend_pop = 1'b0;
        end
        drive_head();
    endtask

    task automatic wait_pops(input int target, input string tag);
        for (int i = 0; i < 50 && n_pops < target; i++) tick();
        check(tag, 64'(n_pops), 64'(target));
    endtask

    task automatic wait_outs(input int target, input string tag);
        for (int i = 0; i < 50 && out_cnt < target; i++) tick();
        check(tag, 64'(out_cnt), 64'(target));
    endtask

    initial begin
        int p, o, first;
        n_cmp = 0; n_err = 0; cyc = 0; n_pops = 0; out_cnt = 0;
        last_pop_cyc = 0; last_out_cyc = 0; last_out_res = '0; last_out_sgn = 1'b0;
        wr_ptr = '0; rd_ptr = '0; pend_pop = 1'b0;
        reset_n           = 1'b0;
        bus.FLUSH_SX2     = 1'b0;
        bus.RES_READY_SX2 = 1'b0;
        drive_head();

        // Reset state
        #2;
        check("rst_valid", 64'(bus.MULT_VALID_RX2), 64'(0));
        check("rst_res",   64'(bus.MULT_RES_RX2),   64'(0));
        check("rst_sgn",   64'(bus.MULT_SIGNED_RX2), 64'(0));
        check("rst_pop",   64'(bus.X1X2_POP_SX2),   64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1: basic low word, two-cycle latency
        bus.RES_READY_SX2 = 1'b1;
        push(64'd42, 64'd0, 1'b0, 1'b0);
        wait_pops(n_pops + 1, "t1_pop");
        p = last_pop_cyc;
        wait_outs(out_cnt + 1, "t1_out");
        check("t1_lat", 64'(last_out_cyc - p), 64'(2));
        check("t1_res", 64'(last_out_res), 64'h2A);
        check("t1_sgn", 64'(last_out_sgn), 64'(0));

        // 2: carry across the split
        push(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1, 1'b0);
        wait_outs(out_cnt + 1, "t2a_out");
        check("t2_msb", 64'(last_out_res), 64'h1);
        push(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        wait_outs(out_cnt + 1, "t2b_out");
        check("t2_lsb", 64'(last_out_res), 64'h0);

        // 3: 64-bit wrap, signed tag forwarded
        push(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b1, 1'b1);
        wait_outs(out_cnt + 1, "t3_out");
        check("t3_res", 64'(last_out_res), 64'h0);
        check("t3_sgn", 64'(last_out_sgn), 64'(1));

        // 4: backpressure with 4 queued entries
        bus.RES_READY_SX2 = 1'b0;
        p = n_pops;
        for (int i = 0; i < 4; i++)
            push(64'h1_0000_0010 + 64'(i), 64'h5, 1'b0, 1'(i));
        repeat (5) begin
            tick();
            if (bus.MULT_VALID_RX2) check("t4_hold", 64'(bus.MULT_RES_RX2), 64'h15);
        end
        check("t4_valid", 64'(bus.MULT_VALID_RX2), 64'(1));
        check("t4_pops", 64'(n_pops - p), 64'(2));
        check("t4_pop_low", 64'(bus.X1X2_POP_SX2), 64'(0));
        bus.RES_READY_SX2 = 1'b1;
        o = out_cnt;
        first = -1;
        for (int i = 0; i < 20 && out_cnt < o + 4; i++) begin
            tick();
            if (first < 0 && out_cnt > o) first = last_out_cyc;
        end
        check("t4_outs", 64'(out_cnt - o), 64'(4));
        check("t4_consec", 64'(last_out_cyc - first), 64'(3));
        check("t4_last", 64'(last_out_res), 64'h18);

        // 5: flush with two entries in flight, ready high in the flush cycle
        bus.RES_READY_SX2 = 1'b0;
        p = n_pops;
        push(64'h100, 64'h23, 1'b0, 1'b0);
        push(64'h200, 64'h45, 1'b0, 1'b0);
        wait_pops(p + 2, "t5_fill");
        push(64'h7, 64'h8, 1'b0, 1'b1);
        bus.FLUSH_SX2     = 1'b1;
        bus.RES_READY_SX2 = 1'b1;
        #1;
        check("t5_valid_pre", 64'(bus.MULT_VALID_RX2), 64'(1));
        check("t5_pop_flush", 64'(bus.X1X2_POP_SX2), 64'(0));
        p = n_pops;
        o = out_cnt;
        tick();
        bus.FLUSH_SX2 = 1'b0;
        check("t5_valid_post", 64'(bus.MULT_VALID_RX2), 64'(0));
        check("t5_nopop", 64'(n_pops - p), 64'(0));
        check("t5_drop", 64'(out_cnt - o), 64'(0));
        wait_pops(p + 1, "t5_pop");
        p = last_pop_cyc;
        wait_outs(o + 1, "t5_out");
        check("t5_lat", 64'(last_out_cyc - p), 64'(2));
        check("t5_res", 64'(last_out_res), 64'hF);
        check("t5_sgn", 64'(last_out_sgn), 64'(1));

        // 6: asynchronous reset with a valid result held
        bus.RES_READY_SX2 = 1'b0;
        push(64'h30, 64'h3, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !bus.MULT_VALID_RX2; i++) tick();
        check("t6_valid_pre", 64'(bus.MULT_VALID_RX2), 64'(1));
        push(64'h40, 64'h4, 1'b0, 1'b0);
        push(64'h50, 64'h5, 1'b0, 1'b0);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_valid_async", 64'(bus.MULT_VALID_RX2), 64'(0));
        check("t6_pop_async", 64'(bus.X1X2_POP_SX2), 64'(0));
        check("t6_res_async", 64'(bus.MULT_RES_RX2), 64'(0));
        p = n_pops;
        repeat (3) begin
            tick();
            check("t6_pop_rst", 64'(bus.X1X2_POP_SX2), 64'(0));
        end
        check("t6_nopop", 64'(n_pops - p), 64'(0));
        reset_n = 1'b1;
        bus.RES_READY_SX2 = 1'b1;
        o = out_cnt;
        wait_pops(p + 1, "t6_pop");
        wait_outs(o + 1, "t6_out");
        check("t6_res", 64'(last_out_res), 64'h55);

        // Random stream with random backpressure
        o = out_cnt;
        for (int i = 0; i < 24; i++)
            push({$urandom(), $urandom()}, {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 400 && out_cnt < o + 24; i++) begin
            bus.RES_READY_SX2 = 1'($urandom_range(0, 1));
            tick();
        end
        check("rnd_outs", 64'(out_cnt - o), 64'(24));
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
